data_memory_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU: takes aluResult as the effective address and performs the load/store.

---
 rtl/mem_pkg.sv | 16 +
 rtl/load_store_align.sv | 49 ++++
 rtl/data_memory_unit.sv | 151 +++++++++++++++
 tb/tb_data_memory_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory stage: access sizes, FSM states, default latency.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/load_store_align.sv
// Big-endian lane steering: store merge into an existing word and load extract/extend.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] word_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] shifted;

  // Lane 0 is the most significant byte, so the shift grows as the lane shrinks.
  always_comb begin
    sh   = '0;
    mask = '0;
    case (size_i)
      SIZE_BYTE: begin
        sh   = {~lane_i, 3'b000};
        mask = 32'h0000_00FF << sh;
      end
      SIZE_HALF: begin
        sh   = {~lane_i[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
      end
      SIZE_WORD: mask = '1;
      default:   mask = '0;
    endcase
  end

  assign merged_o = (word_i & ~mask) | ((store_data_i << sh) & mask);
  assign shifted  = word_i >> sh;

  always_comb begin
    load_o = '0;
    case (size_i)
      SIZE_BYTE: load_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SIZE_WORD: load_o = word_i;
      default:   load_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Memory-access stage: fixed-latency load/store against an internal big-endian word array.
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic        memValid,
  output logic        memStall,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        addrError,
  output logic [1:0]  dbgState
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   read_data_q;
  logic          read_valid_q;
  logic          addr_error_q;

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] mem_word, merged_word, load_word;
  logic        req, illegal, out_of_range, store_commit;

  // Handshake: a request is taken only in IDLE when memValid is high with memRead or
  // memWrite; memStall is high from that cycle until the access leaves WAIT, and
  // memValid seen in any other state is dropped.
  assign req          = memValid && (memRead || memWrite);
  assign out_of_range = |(aluResult >> (IW + 2));
  assign illegal      = (memRead && memWrite) || (memSize == SIZE_ILL) ||
                        ((memSize == SIZE_HALF) && aluResult[0]) ||
                        ((memSize == SIZE_WORD) && (aluResult[1:0] != 2'b00)) ||
                        out_of_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    memStall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          memStall = 1'b1;
          idx_d    = aluResult[IW+1:2];
          lane_d   = aluResult[1:0];
          size_d   = memSize;
          uns_d    = memUnsigned;
          rd_d     = memRead;
          wr_d     = memWrite;
          wdata_d  = storeData;
          if (illegal) begin
            state_d = ST_ERR;
          end else if (LATENCY == 1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        memStall = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_word = mem_q[idx_d];

  load_store_align u_align (
    .lane_i       (lane_d),
    .size_i       (size_d),
    .unsigned_i   (uns_d),
    .store_data_i (wdata_d),
    .word_i       (mem_word),
    .merged_o     (merged_word),
    .load_o       (load_word)
  );

  // Stores land on the edge that enters DONE; gating with rstN keeps a reset edge from committing.
  assign store_commit = rstN && wr_d && (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clk) begin
    if (store_commit) mem_q[idx_d] <= merged_word;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      read_valid_q <= rd_q && ((state_q == ST_DONE) || (state_q == ST_ERR));
      addr_error_q <= (state_q == ST_ERR);
      if (rd_q && (state_q == ST_DONE)) read_data_q <= load_word;
      else if (rd_q && (state_q == ST_ERR)) read_data_q <= '0;
    end
  end

  assign readData  = read_data_q;
  assign readValid = read_valid_q;
  assign addrError = addr_error_q;
  assign dbgState  = state_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed vector bench for data_memory_unit; drives a LATENCY=2 and a LATENCY=1 build in lockstep.
module tb_data_memory_unit;
  import mem_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] aluResult, storeData;
  logic        memRead, memWrite, memUnsigned, memValid;
  logic [1:0]  memSize;

  logic        a_memStall, a_readValid, a_addrError;
  logic [31:0] a_readData;
  logic [1:0]  a_dbgState;
  logic        b_memStall, b_readValid, b_addrError;
  logic [31:0] b_readData;
  logic [1:0]  b_dbgState;

  logic [1:0]  stall_v, rvalid_v, aerr_v;
  logic [31:0] rdata_v [2];
  logic [31:0] last_ld [2];

  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  data_memory_unit #(.MEM_WORDS(256), .LATENCY(2)) dut_a (
    .clk(clk), .rstN(rstN), .aluResult(aluResult), .storeData(storeData),
    .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
    .memUnsigned(memUnsigned), .memValid(memValid), .memStall(a_memStall),
    .readData(a_readData), .readValid(a_readValid), .addrError(a_addrError),
    .dbgState(a_dbgState)
  );

  data_memory_unit #(.MEM_WORDS(256), .LATENCY(1)) dut_b (
    .clk(clk), .rstN(rstN), .aluResult(aluResult), .storeData(storeData),
    .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
    .memUnsigned(memUnsigned), .memValid(memValid), .memStall(b_memStall),
    .readData(b_readData), .readValid(b_readValid), .addrError(b_addrError),
    .dbgState(b_dbgState)
  );

  assign stall_v    = {b_memStall, a_memStall};
  assign rvalid_v   = {b_readValid, a_readValid};
  assign aerr_v     = {b_addrError, a_addrError};
  assign rdata_v[0] = a_readData;
  assign rdata_v[1] = b_readData;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] data, input logic err,
                     input logic [31:0] exp_a, input logic [31:0] exp_b);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.data = data;
    v.err = err; v.exp_a = exp_a; v.exp_b = exp_b;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    memValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    memValid = 1'b1; memRead = rd; memWrite = wr; memSize = size;
    memUnsigned = uns; aluResult = addr; storeData = data;
  endtask

  // One access observed for six cycles on both builds; cycle 0 is the accept cycle.
  task automatic run_vec(input vec_t v, input string name);
    int st[2];
    int rv[2];
    int er[2];
    logic [31:0] rdv[2];
    logic none;
    int lat, exp_st, exp_rv;
    logic [31:0] expd;
    none = !v.rd && !v.wr;
    st = '{0, 0}; rv = '{-1, -1}; er = '{-1, -1}; rdv = '{32'h0, 32'h0};
    @(negedge clk);
    drive(v.rd, v.wr, v.size, v.uns, v.addr, v.data);
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        if (stall_v[k]) st[k]++;
        if (rvalid_v[k] && rv[k] < 0) begin rv[k] = c; rdv[k] = rdata_v[k]; end
        if (aerr_v[k] && er[k] < 0) er[k] = c;
      end
      @(negedge clk);
      if (c == 0 && !none) begin
        // Junk request while busy must be dropped; address changes must not matter.
        drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0, $urandom, $urandom);
      end else begin
        idle_inputs();
      end
    end
    n_vec++;
    for (int k = 0; k < 2; k++) begin
      lat    = (k == 0) ? 2 : 1;
      exp_st = none ? 0 : (v.err ? 1 : lat);
      check($sformatf("%s/dut%0d/stall_cycles", name, k), st[k], exp_st);
      check($sformatf("%s/dut%0d/err_cycle", name, k), er[k], v.err ? 2 : -1);
      if (!(v.rd && v.wr)) begin
        exp_rv = v.rd ? (v.err ? 2 : lat + 1) : -1;
        check($sformatf("%s/dut%0d/rvalid_cycle", name, k), rv[k], exp_rv);
        if (v.rd) begin
          expd = v.err ? 32'h0 : ((k == 0) ? v.exp_a : v.exp_b);
          check($sformatf("%s/dut%0d/rdata", name, k), rdv[k], expd);
          last_ld[k] = expd;
        end
        check($sformatf("%s/dut%0d/rdata_hold", name, k), rdata_v[k], last_ld[k]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    aluResult = '0; storeData = '0; memSize = SIZE_WORD; memUnsigned = 1'b0;
    idle_inputs();
    last_ld = '{32'h0, 32'h0};

    //    rd  wr  size       uns  addr          data          err  exp_a         exp_b
    add(0, 1, SIZE_WORD, 0, 32'h0000_0010, 32'h80FF_7F01, 0, 32'h0,        32'h0);
    add(1, 0, SIZE_WORD, 0, 32'h0000_0010, 32'h0,        0, 32'h80FF_7F01, 32'h80FF_7F01);
    add(1, 0, SIZE_BYTE, 0, 32'h0000_0010, 32'h0,        0, 32'hFFFF_FF80, 32'hFFFF_FF80);
    add(1, 0, SIZE_BYTE, 1, 32'h0000_0011, 32'h0,        0, 32'h0000_00FF, 32'h0000_00FF);
    add(1, 0, SIZE_HALF, 0, 32'h0000_0012, 32'h0,        0, 32'h0000_7F01, 32'h0000_7F01);
    add(1, 0, SIZE_HALF, 1, 32'h0000_0010, 32'h0,        0, 32'h0000_80FF, 32'h0000_80FF);
    add(0, 0, SIZE_WORD, 0, 32'h0000_0010, 32'h5555_5555, 0, 32'h0,        32'h0);
    add(0, 1, SIZE_BYTE, 0, 32'h0000_0013, 32'h1234_56AA, 0, 32'h0,        32'h0);
    add(1, 0, SIZE_WORD, 0, 32'h0000_0010, 32'h0,        0, 32'h80FF_7FAA, 32'h80FF_7FAA);
    add(1, 0, SIZE_WORD, 0, 32'h0000_0012, 32'h0,        1, 32'h0,        32'h0);
    add(1, 0, SIZE_HALF, 0, 32'h0000_0011, 32'h0,        1, 32'h0,        32'h0);
    add(0, 1, SIZE_WORD, 0, 32'h0000_0400, 32'hDEAD_BEEF, 1, 32'h0,        32'h0);
    add(0, 1, SIZE_WORD, 0, 32'h0000_0410, 32'hDEAD_BEEF, 1, 32'h0,        32'h0);
    add(1, 1, SIZE_WORD, 0, 32'h0000_0010, 32'h0,        1, 32'h0,        32'h0);
    add(1, 0, SIZE_ILL,  0, 32'h0000_0010, 32'h0,        1, 32'h0,        32'h0);
    add(1, 0, SIZE_WORD, 0, 32'h0000_0010, 32'h0,        0, 32'h80FF_7FAA, 32'h80FF_7FAA);
    add(0, 1, SIZE_HALF, 0, 32'h0000_0012, 32'h0000_BEEF, 0, 32'h0,        32'h0);
    add(1, 0, SIZE_HALF, 1, 32'h0000_0012, 32'h0,        0, 32'h0000_BEEF, 32'h0000_BEEF);
    add(1, 0, SIZE_HALF, 0, 32'h0000_0012, 32'h0,        0, 32'hFFFF_BEEF, 32'hFFFF_BEEF);
    add(1, 0, SIZE_WORD, 0, 32'h0000_0010, 32'h0,        0, 32'h80FF_BEEF, 32'h80FF_BEEF);
    add(0, 1, SIZE_WORD, 0, 32'h0000_03FC, 32'hCAFE_F00D, 0, 32'h0,        32'h0);
    add(1, 0, SIZE_WORD, 0, 32'h0000_03FC, 32'h0,        0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    add(1, 0, SIZE_BYTE, 1, 32'h0000_03FF, 32'h0,        0, 32'h0000_000D, 32'h0000_000D);
    add(1, 0, SIZE_HALF, 0, 32'h0000_03FE, 32'h0,        0, 32'hFFFF_F00D, 32'hFFFF_F00D);
    add(0, 1, SIZE_WORD, 0, 32'h0000_0020, 32'h1111_2222, 0, 32'h0,        32'h0);

    // Clock/reset
    repeat (3) @(negedge clk);
    check("reset/a_stall", {31'b0, a_memStall}, 32'h0);
    check("reset/a_rvalid", {31'b0, a_readValid}, 32'h0);
    check("reset/a_aerr", {31'b0, a_addrError}, 32'h0);
    check("reset/a_rdata", a_readData, 32'h0);
    check("reset/a_state", {30'b0, a_dbgState}, {30'b0, ST_IDLE});
    check("reset/b_rdata", b_readData, 32'h0);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back accepts on the LATENCY=1 build while the LATENCY=2 build ignores the second.
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("b2b/c0_b_stall", {31'b0, b_memStall}, 32'h1);
    check("b2b/c0_a_stall", {31'b0, a_memStall}, 32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("b2b/c1_b_stall", {31'b0, b_memStall}, 32'h0);
    check("b2b/c1_a_stall", {31'b0, a_memStall}, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h0000_0013, 32'h0);
    #1;
    check("b2b/c2_b_rvalid", {31'b0, b_readValid}, 32'h1);
    check("b2b/c2_b_rdata", b_readData, 32'h80FF_BEEF);
    check("b2b/c2_b_stall", {31'b0, b_memStall}, 32'h1);
    check("b2b/c2_a_stall", {31'b0, a_memStall}, 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("b2b/c3_a_rvalid", {31'b0, a_readValid}, 32'h1);
    check("b2b/c3_a_rdata", a_readData, 32'h80FF_BEEF);
    check("b2b/c3_b_rvalid", {31'b0, b_readValid}, 32'h0);
    @(negedge clk);
    #1;
    check("b2b/c4_b_rvalid", {31'b0, b_readValid}, 32'h1);
    check("b2b/c4_b_rdata", b_readData, 32'h0000_00EF);
    check("b2b/c4_a_rvalid", {31'b0, a_readValid}, 32'h0);
    last_ld = '{32'h80FF_BEEF, 32'h0000_00EF};
    n_vec += 2;
    repeat (3) @(negedge clk);

    // Reset while the LATENCY=2 store sits in WAIT; the LATENCY=1 store has already landed.
    drive(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h0000_0020, 32'h1234_5678);
    @(negedge clk);
    idle_inputs();
    #1;
    check("rst_mid/a_wait_stall", {31'b0, a_memStall}, 32'h1);
    check("rst_mid/a_wait_state", {30'b0, a_dbgState}, {30'b0, ST_WAIT});
    #1 rstN = 1'b0;
    #1;
    check("rst_mid/a_stall", {31'b0, a_memStall}, 32'h0);
    check("rst_mid/a_state", {30'b0, a_dbgState}, {30'b0, ST_IDLE});
    check("rst_mid/a_rdata", a_readData, 32'h0);
    check("rst_mid/a_rvalid", {31'b0, a_readValid}, 32'h0);
    check("rst_mid/a_aerr", {31'b0, a_addrError}, 32'h0);
    check("rst_mid/b_rdata", b_readData, 32'h0);
    last_ld = '{32'h0, 32'h0};
    n_vec++;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    begin
      vec_t v;
      v.rd = 1'b1; v.wr = 1'b0; v.size = SIZE_WORD; v.uns = 1'b0; v.addr = 32'h0000_0020;
      v.data = 32'h0; v.err = 1'b0; v.exp_a = 32'h1111_2222; v.exp_b = 32'h1234_5678;
      run_vec(v, "rst_mid/reload");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
